alu_issue_sched: RTL and testbench
==================================

// Module: alu_issue_sched
// PURPOSE
//  Shares one alu instance between two requesters (req0, req1) using round-robin arbitration.
//  Sequences each operation through the ALU, holding operands for the op-class latency.
//  Captures the result and flag into a response register tagged with the requester id.
//  Sits between the decode/issue stage and the alu; at most one op in flight.
// PARAMETERS
//  OPTION_REG_WIDTH  64                   operand/result width (32 or 64)
//  MUL_LATENCY       3                    EXEC cycles for MULS/MULU (>=1)
//  DIV_LATENCY       OPTION_REG_WIDTH+2   EXEC cycles for DIVS/DIVU/REMS/REMU (>=1)
// PORTS
//  clk            in   1    clock; all state updates on rising edge
//  rst            in   1    synchronous reset, active-high
//  reqN_valid     in   1    (N=0,1) requester N presents an op
//  reqN_ready     out  1    requester N op accepted this cycle when valid&ready
//  reqN_opcode    in   4    op code (encoding below)
//  reqN_rega      in   W    operand A
//  reqN_regb      in   W    operand B
//  alu_valid      out  1    op driven to ALU, operands stable
//  alu_opcode     out  4    registered opcode to ALU
//  alu_rega       out  W    registered operand A to ALU
//  alu_regb       out  W    registered operand B to ALU
//  alu_result     in   W    ALU result, sampled on last EXEC cycle
//  alu_flag       in   1    ALU compare flag, sampled with alu_result
//  rsp_valid      out  1    response available
//  rsp_ready      in   1    consumer takes response when valid&ready
//  rsp_id         out  1    requester that issued the op
//  rsp_result     out  W    captured result
//  rsp_flag       out  1    captured flag
//  rsp_err        out  1    1 = illegal opcode, result forced 0
// BEHAVIOUR
//  Opcodes: 0 CMP,1 ADD,2 SUB,3 OR,4 XOR,5 AND,6 MULS,7 MULU,8 MOVE,9 DIVS,A DIVU,B REMS,C REMU,D-F illegal.
//  Latency L: 1 for 0-5 and 8; MUL_LATENCY for 6-7; DIV_LATENCY for 9-C.
//  FSM IDLE -> EXEC -> RESP -> IDLE; illegal opcode: IDLE -> RESP directly, ALU untouched.
//  IDLE: reqN_ready = granted(N); others 0. Grant: sole valid wins; both valid -> the requester
//   not granted last; last_grant resets to 1 so req0 wins first contention.
//  Accept (cycle T): latch opcode/operands/id into alu_* regs, load cnt = L-1, update last_grant.
//  EXEC: alu_valid=1, alu_* constant; cnt decrements; at cnt==0 capture alu_result/alu_flag
//   into rsp_* and go RESP. Single-cycle op: EXEC at T+1, rsp_valid at T+2.
//  RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake -> IDLE, no accept that cycle.
//  reqN_ready is 0 in EXEC and RESP; a request held valid is served on a later IDLE cycle.
//  Width: W = OPTION_REG_WIDTH; operands passed unmodified; cnt width = clog2(max L)+1.
//  Reset (any state, incl. mid-EXEC/RESP): state IDLE, last_grant=1, cnt=0, all outputs 0;
//   in-flight op and pending response discarded.
//  alu_valid=0 outside EXEC; alu_* hold last values while idle (only alu_valid is qualifying).
// TESTING
//  1 req0 ADD a=5 b=7 alone -> ready0 at T, alu_valid T+1 only, rsp_valid T+2, id=0, result=12.
//  2 req0,req1 both valid ADD each cycle, rsp_ready=1 -> grants alternate 0,1,0,1; first is 0.
//  3 req1 MULU 3*4, MUL_LATENCY=3 -> alu_valid T+1..T+3, rsp_valid T+4, result=12, id=1.
//  4 req0 opcode 4'hE -> rsp_valid T+1, rsp_err=1, rsp_result=0, alu_valid never 1.
//  5 ADD done, rsp_ready=0 for 5 cycles, req1 valid -> rsp_* stable, ready1=0; served after release.
//  6 DIVU in flight, rst pulsed at EXEC cycle 4 -> next cycle IDLE, all outputs 0, no response.

Source files
------------

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - round-robin issue scheduler sharing one ALU between two requesters
module alu_issue_sched #(
    parameter int OPTION_REG_WIDTH = 64,
    parameter int MUL_LATENCY      = 3,
    parameter int DIV_LATENCY      = OPTION_REG_WIDTH + 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [3:0]                  req0_opcode,
    input  logic [OPTION_REG_WIDTH-1:0] req0_rega,
    input  logic [OPTION_REG_WIDTH-1:0] req0_regb,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [3:0]                  req1_opcode,
    input  logic [OPTION_REG_WIDTH-1:0] req1_rega,
    input  logic [OPTION_REG_WIDTH-1:0] req1_regb,
    output logic                        alu_valid,
    output logic [3:0]                  alu_opcode,
    output logic [OPTION_REG_WIDTH-1:0] alu_rega,
    output logic [OPTION_REG_WIDTH-1:0] alu_regb,
    input  logic [OPTION_REG_WIDTH-1:0] alu_result,
    input  logic                        alu_flag,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_id,
    output logic [OPTION_REG_WIDTH-1:0] rsp_result,
    output logic                        rsp_flag,
    output logic                        rsp_err
);

    localparam int MAX_LAT_MD = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int MAX_LAT    = (MAX_LAT_MD > 1) ? MAX_LAT_MD : 1;
    localparam int CNT_W      = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [CNT_W-1:0]              cnt;
    logic                          last_grant;
    logic                          cur_id;
    logic                          grant0;
    logic                          grant1;
    logic                          accept;
    logic                          sel_illegal;
    logic [3:0]                    sel_opcode;
    logic [OPTION_REG_WIDTH-1:0]   sel_rega;
    logic [OPTION_REG_WIDTH-1:0]   sel_regb;

    // EXEC cycles minus one for the given opcode; illegal opcodes never reach EXEC
    function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
        logic [CNT_W-1:0] l;
        l = '0;
        case (op)
            4'h6, 4'h7:             l = CNT_W'(MUL_LATENCY - 1);
            4'h9, 4'hA, 4'hB, 4'hC: l = CNT_W'(DIV_LATENCY - 1);
            default:                l = '0;
        endcase
        return l;
    endfunction

    // Round-robin grant: a sole requester wins, contention goes to the one not granted last
    always_comb begin
        grant0      = req0_valid & (~req1_valid | last_grant);
        grant1      = req1_valid & (~req0_valid | ~last_grant);
        sel_opcode  = grant1 ? req1_opcode : req0_opcode;
        sel_rega    = grant1 ? req1_rega   : req0_rega;
        sel_regb    = grant1 ? req1_regb   : req0_regb;
        sel_illegal = (sel_opcode >= 4'hD);
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req0_ready = grant0 & ~rst;
                req1_ready = grant1 & ~rst;
                if (grant0 | grant1) begin
                    accept    = 1'b1;
                    state_nxt = sel_illegal ? S_RESP : S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight op or pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, latency counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            cnt        <= '0;
            alu_opcode <= '0;
            alu_rega   <= '0;
            alu_regb   <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant1;
                cur_id     <= grant1;
                if (sel_illegal) begin
                    // Illegal ops bypass the ALU and answer with an error straight away
                    rsp_id     <= grant1;
                    rsp_result <= '0;
                    rsp_flag   <= 1'b0;
                    rsp_err    <= 1'b1;
                end else begin
                    alu_opcode <= sel_opcode;
                    alu_rega   <= sel_rega;
                    alu_regb   <= sel_regb;
                    cnt        <= lat_m1(sel_opcode);
                end
            end
            if (state == S_EXEC) begin
                if (cnt == '0) begin
                    rsp_id     <= cur_id;
                    rsp_result <= alu_result;
                    rsp_flag   <= alu_flag;
                    rsp_err    <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    assign alu_valid = (state == S_EXEC);
    assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - directed self-checking bench for alu_issue_sched
module tb_alu_issue_sched;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic         req0_ready;
    logic [3:0]   req0_opcode;
    logic [W-1:0] req0_rega;
    logic [W-1:0] req0_regb;
    logic         req1_valid;
    logic         req1_ready;
    logic [3:0]   req1_opcode;
    logic [W-1:0] req1_rega;
    logic [W-1:0] req1_regb;
    logic         alu_valid;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_rega;
    logic [W-1:0] alu_regb;
    logic [W-1:0] alu_result;
    logic         alu_flag;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_flag;
    logic         rsp_err;

    int n_cmp;
    int n_err;

    alu_issue_sched #(
        .OPTION_REG_WIDTH(W),
        .MUL_LATENCY(3),
        .DIV_LATENCY(W + 2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_opcode(req0_opcode),
        .req0_rega(req0_rega),
        .req0_regb(req0_regb),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_opcode(req1_opcode),
        .req1_rega(req1_rega),
        .req1_regb(req1_regb),
        .alu_valid(alu_valid),
        .alu_opcode(alu_opcode),
        .alu_rega(alu_rega),
        .alu_regb(alu_regb),
        .alu_result(alu_result),
        .alu_flag(alu_flag),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_result(rsp_result),
        .rsp_flag(rsp_flag),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal stand-in ALU covering the ops the bench issues
    always_comb begin
        alu_result = '0;
        alu_flag   = 1'b0;
        case (alu_opcode)
            4'h0: alu_flag   = (alu_rega == alu_regb);
            4'h1: alu_result = alu_rega + alu_regb;
            4'h7: alu_result = alu_rega * alu_regb;
            4'hA: alu_result = (alu_regb != '0) ? alu_rega / alu_regb : '0;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        req0_valid  = 1'b0;
        req0_opcode = '0;
        req0_rega   = '0;
        req0_regb   = '0;
        req1_valid  = 1'b0;
        req1_opcode = '0;
        req1_rega   = '0;
        req1_regb   = '0;
        rsp_ready   = 1'b0;
        drive_edge();
        drive_edge();

        // Reset state
        sample();
        check("rst_alu_valid", W'(alu_valid), 0);
        check("rst_rsp_valid", W'(rsp_valid), 0);
        check("rst_ready0", W'(req0_ready), 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_alu_rega", alu_rega, 0);
        drive_edge();
        rst = 1'b0;

        // 1: single ADD from req0
        req0_valid = 1'b1; req0_opcode = 4'h1; req0_rega = 5; req0_regb = 7;
        sample();
        check("t1_ready0", W'(req0_ready), 1);
        check("t1_ready1", W'(req1_ready), 0);
        check("t1_alu_valid_T", W'(alu_valid), 0);
        drive_edge();
        req0_valid = 1'b0;
        sample();
        check("t1_alu_valid_T1", W'(alu_valid), 1);
        check("t1_alu_opcode", W'(alu_opcode), 1);
        check("t1_alu_rega", alu_rega, 5);
        check("t1_alu_regb", alu_regb, 7);
        check("t1_rsp_valid_T1", W'(rsp_valid), 0);
        drive_edge();
        sample();
        check("t1_alu_valid_T2", W'(alu_valid), 0);
        check("t1_rsp_valid_T2", W'(rsp_valid), 1);
        check("t1_rsp_id", W'(rsp_id), 0);
        check("t1_rsp_result", rsp_result, 12);
        check("t1_rsp_err", W'(rsp_err), 0);
        drive_edge();
        rsp_ready = 1'b1;
        sample();
        check("t1_rsp_hold", W'(rsp_valid), 1);
        drive_edge();
        rsp_ready = 1'b0;
        sample();
        check("t1_rsp_done", W'(rsp_valid), 0);

        // 2: contention, grants alternate starting with req0
        do_reset();
        rsp_ready   = 1'b1;
        req0_valid  = 1'b1; req0_opcode = 4'h1; req0_rega = 1;  req0_regb = 2;
        req1_valid  = 1'b1; req1_opcode = 4'h1; req1_rega = 10; req1_regb = 20;
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("t2_ready0_%0d", i), W'(req0_ready), W'(i % 2 == 0));
            check($sformatf("t2_ready1_%0d", i), W'(req1_ready), W'(i % 2 == 1));
            drive_edge();
            sample();
            check($sformatf("t2_exec_%0d", i), W'(alu_valid), 1);
            check($sformatf("t2_exec_rdy_%0d", i), W'(req0_ready | req1_ready), 0);
            drive_edge();
            sample();
            check($sformatf("t2_rsp_valid_%0d", i), W'(rsp_valid), 1);
            check($sformatf("t2_rsp_id_%0d", i), W'(rsp_id), W'(i % 2));
            check($sformatf("t2_rsp_result_%0d", i), rsp_result, (i % 2 == 0) ? W'(3) : W'(30));
            check($sformatf("t2_rsp_rdy_%0d", i), W'(req0_ready | req1_ready), 0);
            drive_edge();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;

        // 3: MULU from req1 with three EXEC cycles
        do_reset();
        req1_valid = 1'b1; req1_opcode = 4'h7; req1_rega = 3; req1_regb = 4;
        sample();
        check("t3_ready1", W'(req1_ready), 1);
        drive_edge();
        req1_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            sample();
            check($sformatf("t3_alu_valid_T%0d", i), W'(alu_valid), 1);
            check($sformatf("t3_rsp_valid_T%0d", i), W'(rsp_valid), 0);
            drive_edge();
        end
        sample();
        check("t3_alu_valid_T4", W'(alu_valid), 0);
        check("t3_rsp_valid_T4", W'(rsp_valid), 1);
        check("t3_rsp_result", rsp_result, 12);
        check("t3_rsp_id", W'(rsp_id), 1);
        rsp_ready = 1'b1;
        drive_edge();
        rsp_ready = 1'b0;

        // 4: illegal opcode from req0
        req0_valid = 1'b1; req0_opcode = 4'hE; req0_rega = 9; req0_regb = 9;
        sample();
        check("t4_ready0", W'(req0_ready), 1);
        check("t4_alu_valid_T", W'(alu_valid), 0);
        drive_edge();
        req0_valid = 1'b0;
        sample();
        check("t4_rsp_valid", W'(rsp_valid), 1);
        check("t4_rsp_err", W'(rsp_err), 1);
        check("t4_rsp_result", rsp_result, 0);
        check("t4_rsp_id", W'(rsp_id), 0);
        check("t4_alu_valid", W'(alu_valid), 0);
        check("t4_alu_opcode", W'(alu_opcode), 7);
        rsp_ready = 1'b1;
        drive_edge();
        rsp_ready = 1'b0;

        // 5: response back-pressure with req1 waiting
        req0_valid = 1'b1; req0_opcode = 4'h1; req0_rega = 100; req0_regb = 23;
        drive_edge();
        req0_valid = 1'b0;
        drive_edge();
        req1_valid = 1'b1; req1_opcode = 4'h1; req1_rega = 1; req1_regb = 1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("t5_rsp_valid_%0d", i), W'(rsp_valid), 1);
            check($sformatf("t5_rsp_result_%0d", i), rsp_result, 123);
            check($sformatf("t5_rsp_id_%0d", i), W'(rsp_id), 0);
            check($sformatf("t5_ready1_%0d", i), W'(req1_ready), 0);
            drive_edge();
        end
        rsp_ready = 1'b1;
        drive_edge();
        rsp_ready = 1'b0;
        sample();
        check("t5_idle_rsp_valid", W'(rsp_valid), 0);
        check("t5_ready1_served", W'(req1_ready), 1);
        drive_edge();
        req1_valid = 1'b0;
        drive_edge();
        sample();
        check("t5_rsp2_valid", W'(rsp_valid), 1);
        check("t5_rsp2_id", W'(rsp_id), 1);
        check("t5_rsp2_result", rsp_result, 2);
        rsp_ready = 1'b1;
        drive_edge();
        rsp_ready = 1'b0;

        // 6: reset during a DIVU
        req0_valid = 1'b1; req0_opcode = 4'hA; req0_rega = 100; req0_regb = 7;
        drive_edge();
        req0_valid = 1'b0;
        drive_edge();
        drive_edge();
        drive_edge();
        sample();
        check("t6_exec4_alu_valid", W'(alu_valid), 1);
        check("t6_exec4_alu_opcode", W'(alu_opcode), 4'hA);
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;
        sample();
        check("t6_alu_valid", W'(alu_valid), 0);
        check("t6_rsp_valid", W'(rsp_valid), 0);
        check("t6_alu_opcode", W'(alu_opcode), 0);
        check("t6_alu_rega", alu_rega, 0);
        check("t6_rsp_result", rsp_result, 0);
        check("t6_rsp_id", W'(rsp_id), 0);
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            sample();
            check($sformatf("t6_no_rsp_%0d", i), W'(rsp_valid | alu_valid), 0);
        end
        drive_edge();
        req0_valid = 1'b1; req0_opcode = 4'h1;
        req1_valid = 1'b1; req1_opcode = 4'h1;
        sample();
        check("t6_post_rst_ready0", W'(req0_ready), 1);
        check("t6_post_rst_ready1", W'(req1_ready), 0);
        drive_edge();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drive_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
